// File: rtl/mult_issue_ctrl_tainttrack.sv
// Operand-issue / result-capture wrapper for a taint-tracked multiplier, with GLIFT-style taint shadows.
// Latency: accept -> start 1 cycle, start -> result = multiplier done time + 1, or TIMEOUT wait cycles.
// Backpressure: one op in flight; in_ready only in IDLE, result held in HOLD until out_ready.
module mult_issue_ctrl_tainttrack #(
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    input  logic                 in_valid_t,
    output logic                 in_ready,
    output logic                 in_ready_t,
    input  logic [WIDTH-1:0]     in_multiplier,
    input  logic [WIDTH-1:0]     in_multiplier_t,
    input  logic [WIDTH-1:0]     in_multiplicand,
    input  logic [WIDTH-1:0]     in_multiplicand_t,

    output logic                 mul_start,
    output logic                 mul_start_t,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplier_t,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplicand_t,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic [2*WIDTH-1:0]   mul_product_t,
    input  logic                 mul_done,
    input  logic                 mul_done_t,

    output logic                 out_valid,
    output logic                 out_valid_t,
    input  logic                 out_ready,
    input  logic                 out_ready_t,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [2*WIDTH-1:0]   out_product_t,
    output logic                 out_err,
    output logic                 out_err_t
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          ctrl_t;

    assign in_ready    = (state == IDLE);
    assign mul_start   = (state == ISSUE);
    assign out_valid   = (state == HOLD);
    assign in_ready_t  = ctrl_t;
    assign mul_start_t = ctrl_t;
    assign out_valid_t = ctrl_t;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            ctrl_t             <= 1'b0;
            mul_multiplier     <= '0;
            mul_multiplier_t   <= '0;
            mul_multiplicand   <= '0;
            mul_multiplicand_t <= '0;
            out_product        <= '0;
            out_product_t      <= '0;
            out_err            <= 1'b0;
            out_err_t          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_t)
                        ctrl_t <= 1'b1;
                    if (in_valid) begin
                        mul_multiplier     <= in_multiplier;
                        mul_multiplicand   <= in_multiplicand;
                        mul_multiplier_t   <= in_multiplier_t   | {WIDTH{ctrl_t | in_valid_t}};
                        mul_multiplicand_t <= in_multiplicand_t | {WIDTH{ctrl_t | in_valid_t}};
                        state              <= ISSUE;
                    end
                end
                // mul_done is deliberately not looked at here: it may still be high from the previous op.
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_done_t)
                        ctrl_t <= 1'b1;
                    if (mul_done) begin
                        out_product   <= mul_product;
                        out_product_t <= mul_product_t | {(2*WIDTH){ctrl_t | mul_done_t}};
                        out_err       <= 1'b0;
                        out_err_t     <= ctrl_t | mul_done_t;
                        state         <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        out_product   <= '0;
                        out_product_t <= {(2*WIDTH){ctrl_t}};
                        out_err       <= 1'b1;
                        out_err_t     <= ctrl_t | mul_done_t;
                        state         <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready_t)
                        ctrl_t <= 1'b1;
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
